// File: rtl/rv32i_prefetch_fetch.sv
// RV32I fetch stage with a pipelined instruction prefetch queue.
// Keeps several bus requests in flight and feeds decode from a small FIFO.
module rv32i_prefetch_fetch #(
    parameter logic [31:0] PC_RESET        = 32'h0000_0000,
    parameter int          QUEUE_DEPTH     = 4,
    parameter int          MAX_OUTSTANDING = 2
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    output logic [31:0] o_iaddr,
    output logic        o_stb_inst,
    input  logic        i_ack_inst,
    input  logic [31:0] i_inst,
    input  logic        i_writeback_change_pc,
    input  logic [31:0] i_writeback_next_pc,
    input  logic        i_alu_change_pc,
    input  logic [31:0] i_alu_next_pc,
    output logic [31:0] o_pc,
    output logic [31:0] o_inst,
    output logic        o_ce,
    input  logic        i_stall,
    input  logic        i_flush
);

    localparam int AW = $clog2(QUEUE_DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] MAX_C   = CW'(MAX_OUTSTANDING);
    localparam logic [CW:0]   DEPTH_C = (CW+1)'(QUEUE_DEPTH);

    logic [CW-1:0] outstanding;
    logic [CW-1:0] drop;
    logic [CW-1:0] occ;
    logic [31:0]   resp_pc;
    logic [AW-1:0] wptr;
    logic [AW-1:0] rptr;
    logic [31:0]   q_pc   [QUEUE_DEPTH];
    logic [31:0]   q_inst [QUEUE_DEPTH];

    logic          redirect;
    logic [31:0]   target;
    logic [CW:0]   inflight;
    logic          ack_ok;
    logic          push;
    logic          pop;
    logic          empty;

    assign redirect = i_writeback_change_pc | i_alu_change_pc;
    assign target   = i_writeback_change_pc ? i_writeback_next_pc
                                            : i_alu_next_pc;
    assign inflight = {1'b0, outstanding} + {1'b0, occ};
    assign empty    = (occ == '0);

    // Every outstanding request owns a queue slot, so a push never overflows.
    assign o_stb_inst = i_rst_n && !redirect
                     && (outstanding < MAX_C)
                     && (inflight < DEPTH_C);

    assign ack_ok = i_ack_inst && (outstanding != '0);
    assign push   = ack_ok && (drop == '0) && !redirect;
    assign pop    = !redirect && !i_stall && !i_flush && !empty;

    always_ff @(posedge i_clk) begin
        if (push) begin
            q_pc[wptr]   <= resp_pc;
            q_inst[wptr] <= i_inst;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_iaddr     <= PC_RESET;
            resp_pc     <= PC_RESET;
            outstanding <= '0;
            drop        <= '0;
            occ         <= '0;
            wptr        <= '0;
            rptr        <= '0;
        end else begin
            outstanding <= outstanding + CW'(o_stb_inst) - CW'(ack_ok);
            if (redirect) begin
                o_iaddr <= target;
                resp_pc <= target;
                // Everything still in flight belongs to the old path.
                drop    <= outstanding - CW'(ack_ok);
                occ     <= '0;
                wptr    <= '0;
                rptr    <= '0;
            end else begin
                if (o_stb_inst) o_iaddr <= o_iaddr + 32'd4;
                if (push) begin
                    resp_pc <= resp_pc + 32'd4;
                    wptr    <= wptr + 1'b1;
                end
                if (pop) rptr <= rptr + 1'b1;
                if (ack_ok && drop != '0) drop <= drop - 1'b1;
                occ <= occ + CW'(push) - CW'(pop);
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_pc   <= '0;
            o_inst <= '0;
            o_ce   <= 1'b0;
        end else if (redirect) begin
            o_ce <= 1'b0;
        end else if (!i_stall) begin
            if (i_flush) begin
                o_ce <= 1'b0;
            end else begin
                o_ce <= !empty;
                if (!empty) begin
                    o_pc   <= q_pc[rptr];
                    o_inst <= q_inst[rptr];
                end
            end
        end
    end

endmodule

// File: tb/tb_rv32i_prefetch_fetch.sv
// Scoreboard bench for rv32i_prefetch_fetch: in-order bus model,
// expected fetch stream queued by stimulus, checked by a monitor.
module tb_rv32i_prefetch_fetch;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] iaddr;
    logic        stb;
    logic        bus_ack = 1'b0;
    logic [31:0] bus_inst = '0;
    logic        stray_ack = 1'b0;
    logic        ack;
    logic [31:0] inst_in;
    logic        wb_chg = 1'b0;
    logic [31:0] wb_pc = '0;
    logic        alu_chg = 1'b0;
    logic [31:0] alu_pc = '0;
    logic [31:0] pc;
    logic [31:0] inst;
    logic        ce;
    logic        stall = 1'b0;
    logic        flush = 1'b0;

    assign ack     = bus_ack | stray_ack;
    assign inst_in = stray_ack ? 32'hDEAD_BEEF : bus_inst;

    rv32i_prefetch_fetch #(
        .PC_RESET(32'h0000_0000),
        .QUEUE_DEPTH(4),
        .MAX_OUTSTANDING(2)
    ) dut (
        .i_clk(clk),
        .i_rst_n(rst_n),
        .o_iaddr(iaddr),
        .o_stb_inst(stb),
        .i_ack_inst(ack),
        .i_inst(inst_in),
        .i_writeback_change_pc(wb_chg),
        .i_writeback_next_pc(wb_pc),
        .i_alu_change_pc(alu_chg),
        .i_alu_next_pc(alu_pc),
        .o_pc(pc),
        .o_inst(inst),
        .o_ce(ce),
        .i_stall(stall),
        .i_flush(flush)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } exp_t;

    typedef struct {
        logic [31:0] a;
        int          c;
    } req_t;

    exp_t exp_q[$];
    req_t pend[$];
    int   errors = 0;
    int   checks = 0;
    int   consumed = 0;
    int   cyc = 0;
    int   lat = 1;

    function automatic logic [31:0] mem(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'h1357_9BDF;
    endfunction

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic push_seq(input logic [31:0] s, input int n);
        exp_q.delete();
        for (int i = 0; i < n; i++) begin
            logic [31:0] a;
            a = s + 32'(4 * i);
            exp_q.push_back('{pc: a, inst: mem(a)});
        end
    endtask

    task automatic wait_consumed(input int n);
        int target;
        bit ok;
        target = consumed + n;
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(posedge clk);
            if (consumed >= target) begin
                ok = 1'b1;
                break;
            end
        end
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL wait_consumed: got %0d expected %0d",
                     consumed, target);
        end
    endtask

    task automatic redirect(input bit wb, input logic [31:0] t);
        @(posedge clk);
        #2;
        wb_chg  = wb;
        wb_pc   = t;
        alu_chg = !wb;
        alu_pc  = t;
        @(negedge clk);
        chk("stb_in_redirect", 32'(stb), 32'd0);
        #1;
        push_seq(t, 64);
        @(posedge clk);
        #2;
        wb_chg  = 1'b0;
        alu_chg = 1'b0;
        chk("iaddr_after_redirect", iaddr, t);
        chk("ce_after_redirect", 32'(ce), 32'd0);
    endtask

    // Request capture: a strobe high before the edge is issued at it.
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n && stb) pend.push_back('{a: iaddr, c: cyc});
        end
    end

    // In-order responder with programmable latency.
    initial begin
        forever begin
            @(posedge clk);
            cyc++;
            #1;
            bus_ack = 1'b0;
            if (!rst_n) begin
                pend.delete();
            end else if (pend.size() > 0 && cyc >= pend[0].c + lat) begin
                bus_ack  = 1'b1;
                bus_inst = mem(pend[0].a);
                void'(pend.pop_front());
            end
        end
    end

    // Decode consumes the output whenever it is valid and not stalled.
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n && ce && !stall) begin
                if (exp_q.size() == 0) begin
                    chk("scoreboard_empty", pc, 32'hFFFF_FFFF);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("o_pc", pc, e.pc);
                    chk("o_inst", inst, e.inst);
                end
                consumed++;
            end
        end
    end

    initial begin
        #2;
        chk("rst_iaddr", iaddr, 32'h0);
        chk("rst_stb", 32'(stb), 32'd0);
        chk("rst_pc", pc, 32'h0);
        chk("rst_inst", inst, 32'h0);
        chk("rst_ce", 32'(ce), 32'd0);
        push_seq(32'h0, 64);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;

        @(posedge clk);
        #2;
        chk("ce_edge1", 32'(ce), 32'd0);
        @(posedge clk);
        #2;
        chk("ce_edge2", 32'(ce), 32'd0);
        @(posedge clk);
        #2;
        chk("ce_edge3", 32'(ce), 32'd1);
        chk("pc_edge3", pc, 32'h0);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("ce_stream", 32'(ce), 32'd1);
        end

        @(posedge clk);
        #2;
        stall = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (i == 9) begin
                chk("stb_full", 32'(stb), 32'd0);
                chk("ce_stall", 32'(ce), 32'd1);
            end
        end
        @(posedge clk);
        #2;
        stall = 1'b0;
        wait_consumed(8);

        lat = 3;
        begin
            bit hit;
            hit = 1'b0;
            for (int i = 0; i < 50; i++) begin
                @(posedge clk);
                #2;
                if (pend.size() == 2) begin
                    hit = 1'b1;
                    break;
                end
            end
            chk("two_in_flight", 32'(hit), 32'd1);
        end
        alu_chg = 1'b1;
        alu_pc  = 32'h100;
        @(negedge clk);
        chk("stb_in_redirect", 32'(stb), 32'd0);
        #1;
        push_seq(32'h100, 64);
        @(posedge clk);
        #2;
        alu_chg = 1'b0;
        chk("iaddr_0x100", iaddr, 32'h100);
        chk("ce_after_0x100", 32'(ce), 32'd0);
        wait_consumed(4);
        lat = 1;

        @(posedge clk);
        #2;
        wb_chg  = 1'b1;
        wb_pc   = 32'h80;
        alu_chg = 1'b1;
        alu_pc  = 32'h200;
        @(posedge clk);
        #2;
        chk("wb_priority", iaddr, 32'h80);
        wb_chg = 1'b0;
        alu_pc = 32'h300;
        @(negedge clk);
        chk("stb_b2b", 32'(stb), 32'd0);
        #1;
        push_seq(32'h300, 64);
        @(posedge clk);
        #2;
        alu_chg = 1'b0;
        chk("iaddr_0x300", iaddr, 32'h300);
        wait_consumed(4);

        @(posedge clk);
        #2;
        chk("ce_before_flush", 32'(ce), 32'd1);
        stall = 1'b1;
        flush = 1'b1;
        @(negedge clk);
        chk("ce_flush_stalled", 32'(ce), 32'd1);
        @(posedge clk);
        #2;
        chk("ce_flush_ignored", 32'(ce), 32'd1);
        stall = 1'b0;
        @(posedge clk);
        #2;
        flush = 1'b0;
        chk("ce_flushed", 32'(ce), 32'd0);
        @(posedge clk);
        #2;
        chk("ce_after_flush", 32'(ce), 32'd1);
        wait_consumed(3);

        redirect(1'b0, 32'hFFFF_FFF8);
        wait_consumed(5);

        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_iaddr", iaddr, 32'h0);
        chk("mid_rst_stb", 32'(stb), 32'd0);
        chk("mid_rst_pc", pc, 32'h0);
        chk("mid_rst_inst", inst, 32'h0);
        chk("mid_rst_ce", 32'(ce), 32'd0);
        push_seq(32'h0, 64);
        @(posedge clk);
        #4;
        rst_n     = 1'b1;
        stray_ack = 1'b1;
        @(posedge clk);
        #2;
        stray_ack = 1'b0;
        wait_consumed(6);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
